// File: rtl/dfm_pkg.sv
// Types and constants shared by the frequency-measurement datapath blocks.
// The measurement word is packed as {sig_cnt, ref_cnt}.
package dfm_pkg;

    localparam int unsigned CNT_W        = 32;
    localparam int unsigned MAX_LOG2_DEF = 7;

    typedef struct packed {
        logic [CNT_W-1:0] sig_cnt;
        logic [CNT_W-1:0] ref_cnt;
    } meas_smp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_EMIT
    } avg_state_t;

endpackage

// File: rtl/avg_lane.sv
// One averaging lane: wide accumulator plus round-half-up shifter.
// On emit the completing sample is folded in directly, so the mean leaves one cycle after it.
module avg_lane
    import dfm_pkg::*;
#(
    parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF,
    parameter int unsigned LOG2_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CNT_W-1:0]  smp_i,
    input  logic              add_en_i,
    input  logic              clr_i,
    input  logic              emit_i,
    input  logic [LOG2_W-1:0] shift_i,
    output logic [CNT_W-1:0]  avg_o
);

    localparam int unsigned ACC_W = CNT_W + MAX_LOG2;
    localparam int unsigned SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] avg_q, avg_d;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] rnd;

    always_comb begin
        sum   = {1'b0, acc_q} + SUM_W'(smp_i);
        // Half-LSB rounding term; shifting back down yields zero when shift_i is 0.
        rnd   = (SUM_W'(1) << shift_i) >> 1;
        acc_d = acc_q;
        avg_d = avg_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_en_i) begin
            if (emit_i) begin
                acc_d = '0;
                avg_d = CNT_W'((sum + rnd) >> shift_i);
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end

    assign avg_o = avg_q;

endmodule

// File: rtl/meas_avg.sv
// Block averager: sums 2^L measurement words per lane and emits one rounded mean word.
// Holds the sample count, the latched exponent and the block FSM; the lanes hold the data.
module meas_avg
    import dfm_pkg::*;
#(
    parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF,
    parameter int unsigned LOG2_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              smp_vld_i,
    input  logic [63:0]       smp_data_i,
    input  logic [LOG2_W-1:0] avg_log2_i,
    input  logic              clr_i,
    output logic              avg_vld_o,
    output logic [63:0]       avg_data_o,
    output logic              busy_o
);

    localparam int unsigned CW = MAX_LOG2 + 1;

    avg_state_t        state_q;
    logic [CW-1:0]     cnt_q;
    logic [LOG2_W-1:0] l_lat_q;
    logic              vld_q;
    logic              busy_q;

    meas_smp_t         smp;
    logic [LOG2_W-1:0] l_clamp;
    logic [LOG2_W-1:0] l_eff;
    logic [CW-1:0]     blk_len;
    logic              take;
    logic              blk_end;
    logic [CNT_W-1:0]  sig_avg;
    logic [CNT_W-1:0]  ref_avg;

    assign smp = smp_data_i;

    always_comb begin
        l_clamp = (avg_log2_i > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : avg_log2_i;
        // Outside ACC the count is zero, so the incoming sample opens a block with a fresh exponent.
        l_eff   = (state_q == ST_ACC) ? l_lat_q : l_clamp;
        blk_len = CW'(1) << l_eff;
        take    = smp_vld_i && !clr_i;
        blk_end = take && ((cnt_q + CW'(1)) == blk_len);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            l_lat_q <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (clr_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (blk_end) begin
            state_q <= ST_EMIT;
            cnt_q   <= '0;
            l_lat_q <= l_eff;
            vld_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else if (take) begin
            state_q <= ST_ACC;
            cnt_q   <= cnt_q + CW'(1);
            l_lat_q <= l_eff;
            vld_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            vld_q <= 1'b0;
            if (state_q == ST_EMIT) begin
                state_q <= ST_IDLE;
            end
        end
    end

    avg_lane #(
        .MAX_LOG2 (MAX_LOG2),
        .LOG2_W   (LOG2_W)
    ) u_sig_lane (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .smp_i    (smp.sig_cnt),
        .add_en_i (take),
        .clr_i    (clr_i),
        .emit_i   (blk_end),
        .shift_i  (l_eff),
        .avg_o    (sig_avg)
    );

    avg_lane #(
        .MAX_LOG2 (MAX_LOG2),
        .LOG2_W   (LOG2_W)
    ) u_ref_lane (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .smp_i    (smp.ref_cnt),
        .add_en_i (take),
        .clr_i    (clr_i),
        .emit_i   (blk_end),
        .shift_i  (l_eff),
        .avg_o    (ref_avg)
    );

    assign avg_vld_o  = vld_q;
    assign avg_data_o = {sig_avg, ref_avg};
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_meas_avg.sv
// Directed bench for meas_avg: a block-sum model predicts every output each cycle,
// and hand-computed literals pin the model at the interesting points.
module tb_meas_avg;

    logic        clk = 1'b0;
    logic        rst;
    logic        smp_vld;
    logic [63:0] smp_data;
    logic [2:0]  avg_log2;
    logic        clr;
    logic        avg_vld;
    logic [63:0] avg_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    int              m_n;
    int              m_l;
    longint unsigned m_sig;
    longint unsigned m_ref;
    bit              exp_vld;
    bit              exp_busy;
    logic [63:0]     exp_data;

    always #5 clk = ~clk;

    meas_avg #(
        .MAX_LOG2 (7),
        .LOG2_W   (3)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .smp_vld_i  (smp_vld),
        .smp_data_i (smp_data),
        .avg_log2_i (avg_log2),
        .clr_i      (clr),
        .avg_vld_o  (avg_vld),
        .avg_data_o (avg_data),
        .busy_o     (busy)
    );

    // Mean rounded half up, computed as floor(s/2^L + 1/2) by integer division.
    function automatic longint unsigned rmean(input longint unsigned s, input int l);
        longint unsigned den;
        den = 64'd1 << (l + 1);
        return (2 * s + (64'd1 << l)) / den;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_n = 0; m_sig = 0; m_ref = 0; m_l = 0;
            exp_vld = 0; exp_busy = 0; exp_data = '0;
        end else if (clr) begin
            m_n = 0; m_sig = 0; m_ref = 0;
            exp_vld = 0; exp_busy = 0;
        end else if (smp_vld) begin
            if (m_n == 0) m_l = (avg_log2 > 3'd7) ? 7 : int'(avg_log2);
            m_sig += longint'(smp_data[63:32]);
            m_ref += longint'(smp_data[31:0]);
            m_n++;
            exp_vld = 0;
            if (m_n == (1 << m_l)) begin
                exp_data = {32'(rmean(m_sig, m_l)), 32'(rmean(m_ref, m_l))};
                exp_vld  = 1;
                m_n = 0; m_sig = 0; m_ref = 0;
            end
            exp_busy = (m_n != 0);
        end else begin
            exp_vld = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit v,
                       input logic [31:0] s, input logic [31:0] rf, input logic [2:0] l);
        rst = r; clr = c; smp_vld = v; smp_data = {s, rf}; avg_log2 = l;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n, input logic [2:0] l);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, 32'd0, l);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("avg_vld_o", {63'd0, avg_vld}, {63'd0, exp_vld});
            check("avg_data_o", avg_data, exp_data);
            check("busy_o", {63'd0, busy}, {63'd0, exp_busy});
        end
    end

    initial begin
        cyc(1, 0, 0, 32'd0, 32'd0, 3'd0);
        cyc(1, 0, 0, 32'd0, 32'd0, 3'd0);
        check("reset_data", avg_data, 64'd0);
        check("reset_vld_busy", {62'd0, avg_vld, busy}, 64'd0);
        chk_on = 1'b1;
        cyc(0, 0, 0, 32'd0, 32'd0, 3'd0);

        // L=0 pass-through
        cyc(0, 0, 1, 32'd100, 32'd200, 3'd0);
        check("l0_first", {63'd0, avg_vld, avg_data}, {1'b1, 32'd100, 32'd200});
        check("l0_model", exp_data, {32'd100, 32'd200});
        cyc(0, 0, 1, 32'd101, 32'd201, 3'd0);
        check("l0_second", {63'd0, avg_vld, avg_data}, {1'b1, 32'd101, 32'd201});
        idle(2, 3'd0);

        // L=2: sig 10,11,11,11 -> 11; ref 3,4,5,6 -> 5
        cyc(0, 0, 1, 32'd10, 32'd3, 3'd2);
        check("l2_busy_first", {63'd0, busy}, 64'd1);
        cyc(0, 0, 1, 32'd11, 32'd4, 3'd2);
        cyc(0, 0, 1, 32'd11, 32'd5, 3'd2);
        check("l2_no_early", {63'd0, avg_vld}, 64'd0);
        cyc(0, 0, 1, 32'd11, 32'd6, 3'd2);
        check("l2_mean", {63'd0, avg_vld, avg_data}, {1'b1, 32'd11, 32'd5});
        check("l2_model", exp_data, {32'd11, 32'd5});
        idle(2, 3'd2);

        // L=7, 128 full-scale samples, then a new L=1 block starting in the EMIT cycle
        for (int i = 0; i < 128; i++) cyc(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7);
        check("l7_full_scale", {63'd0, avg_vld, avg_data}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        cyc(0, 0, 1, 32'd4, 32'd1, 3'd1);
        check("emit_cycle_sample_busy", {63'd0, busy}, 64'd1);
        cyc(0, 0, 1, 32'd7, 32'd2, 3'd1);
        check("emit_cycle_block", {63'd0, avg_vld, avg_data}, {1'b1, 32'd6, 32'd2});
        idle(2, 3'd1);

        // L=3 latched; exponent changes to 1 mid-block are ignored
        for (int i = 1; i <= 8; i++)
            cyc(0, 0, 1, 32'(i * 10), 32'd8, (i <= 3) ? 3'd3 : 3'd1);
        check("latched_l3", {63'd0, avg_vld, avg_data}, {1'b1, 32'd45, 32'd8});
        idle(1, 3'd1);
        cyc(0, 0, 1, 32'd5, 32'd0, 3'd1);
        cyc(0, 0, 1, 32'd6, 32'd1, 3'd1);
        check("next_block_l1", {63'd0, avg_vld, avg_data}, {1'b1, 32'd6, 32'd1});
        idle(2, 3'd2);

        // clr with the 2nd sample drops the block and that sample
        cyc(0, 0, 1, 32'd1000, 32'd1000, 3'd2);
        cyc(0, 1, 1, 32'd2000, 32'd2000, 3'd2);
        check("clr_no_strobe", {62'd0, avg_vld, busy}, 64'd0);
        cyc(0, 0, 1, 32'd4, 32'd0, 3'd2);
        cyc(0, 0, 1, 32'd4, 32'd0, 3'd2);
        cyc(0, 0, 1, 32'd4, 32'd0, 3'd2);
        cyc(0, 0, 1, 32'd5, 32'd3, 3'd2);
        check("after_clr_mean", {63'd0, avg_vld, avg_data}, {1'b1, 32'd4, 32'd1});
        idle(1, 3'd1);

        // clr coinciding with a block-end sample
        cyc(0, 0, 1, 32'd50, 32'd50, 3'd1);
        cyc(0, 1, 1, 32'd60, 32'd60, 3'd1);
        check("clr_block_end", {63'd0, avg_vld, avg_data}, {1'b0, 32'd4, 32'd1});
        idle(2, 3'd2);

        // reset mid-block
        cyc(0, 0, 1, 32'd77, 32'd77, 3'd2);
        cyc(0, 0, 1, 32'd77, 32'd77, 3'd2);
        cyc(1, 0, 0, 32'd0, 32'd0, 3'd2);
        check("mid_reset", {62'd0, avg_vld, busy, avg_data}, 64'd0);
        cyc(0, 0, 1, 32'd8, 32'd100, 3'd2);
        cyc(0, 0, 1, 32'd8, 32'd100, 3'd2);
        cyc(0, 0, 1, 32'd8, 32'd100, 3'd2);
        cyc(0, 0, 1, 32'd9, 32'd100, 3'd2);
        check("after_reset_mean", {63'd0, avg_vld, avg_data}, {1'b1, 32'd8, 32'd100});
        idle(3, 3'd0);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
